// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the fetch and load/store paths.
// It keeps one transaction outstanding and grants round-robin on contention.
//
// state | meaning
// IDLE  | no transaction in flight; pick a requester and latch its payload
// REQ   | mem_req_o and payload held stable until mem_gnt_i
// RESP  | waiting for mem_rvalid_i while the watchdog counts toward TIMEOUT
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    input  logic [1:0]        fetch_size_i,
    output logic              fetch_ack_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    output logic              fetch_err_o,
    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [1:0]        d_size_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [TAG_W-1:0]  d_tag_i,
    output logic              d_resp_valid_o,
    output logic [TAG_W-1:0]  d_resp_tag_o,
    output logic [DATA_W-1:0] d_resp_rdata_o,
    output logic              d_resp_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_size_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                owner_d_q, owner_d_d;
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                fetch_ack_q, fetch_ack_d;
    logic [DATA_W-1:0]   fetch_rdata_q, fetch_rdata_d;
    logic                fetch_err_q, fetch_err_d;
    logic                d_resp_valid_q, d_resp_valid_d;
    logic [TAG_W-1:0]    d_resp_tag_q, d_resp_tag_d;
    logic [DATA_W-1:0]   d_resp_rdata_q, d_resp_rdata_d;
    logic                d_resp_err_q, d_resp_err_d;

    logic                pend_f, pend_d, sel_d, timeout, retire;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    // Data wins a tie only when fetch was served last.
    assign pend_f    = fetch_req_i & ~flush_i;
    assign pend_d    = d_valid_i;
    assign sel_d     = pend_d & (~pend_f | ~last_d_q);
    assign d_ready_o = (state_q == IDLE) & sel_d;

    assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign retire    = mem_rvalid_i | timeout;
    assign rsp_rdata = (mem_rvalid_i & ~mem_we_q) ? mem_rdata_i : '0;
    assign rsp_err   = mem_rvalid_i ? mem_err_i : 1'b1;

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        owner_d_d      = owner_d_q;
        drop_d         = drop_q;
        cnt_d          = cnt_q;
        tag_d          = tag_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_size_d     = mem_size_q;
        mem_wdata_d    = mem_wdata_q;
        fetch_ack_d    = 1'b0;
        fetch_rdata_d  = fetch_rdata_q;
        fetch_err_d    = fetch_err_q;
        d_resp_valid_d = 1'b0;
        d_resp_tag_d   = d_resp_tag_q;
        d_resp_rdata_d = d_resp_rdata_q;
        d_resp_err_d   = d_resp_err_q;

        case (state_q)
            IDLE: begin
                if (pend_f | pend_d) begin
                    owner_d_d = sel_d;
                    last_d_d  = sel_d;
                    mem_req_d = 1'b1;
                    state_d   = REQ;
                    if (sel_d) begin
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_size_d  = d_size_i;
                        mem_wdata_d = d_wdata_i;
                        tag_d       = d_tag_i;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = fetch_addr_i;
                        mem_size_d  = fetch_size_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (flush_i & ~owner_d_q) drop_d = 1'b1;
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (flush_i & ~owner_d_q) drop_d = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (retire) begin
                    if (owner_d_q) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_tag_d   = tag_q;
                        d_resp_rdata_d = rsp_rdata;
                        d_resp_err_d   = rsp_err;
                    end else if (!(drop_q | flush_i)) begin
                        fetch_ack_d   = 1'b1;
                        fetch_rdata_d = rsp_rdata;
                        fetch_err_d   = rsp_err;
                    end
                    drop_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b0;
            owner_d_q      <= 1'b0;
            drop_q         <= 1'b0;
            cnt_q          <= '0;
            tag_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_size_q     <= '0;
            mem_wdata_q    <= '0;
            fetch_ack_q    <= 1'b0;
            fetch_rdata_q  <= '0;
            fetch_err_q    <= 1'b0;
            d_resp_valid_q <= 1'b0;
            d_resp_tag_q   <= '0;
            d_resp_rdata_q <= '0;
            d_resp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            owner_d_q      <= owner_d_d;
            drop_q         <= drop_d;
            cnt_q          <= cnt_d;
            tag_q          <= tag_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_size_q     <= mem_size_d;
            mem_wdata_q    <= mem_wdata_d;
            fetch_ack_q    <= fetch_ack_d;
            fetch_rdata_q  <= fetch_rdata_d;
            fetch_err_q    <= fetch_err_d;
            d_resp_valid_q <= d_resp_valid_d;
            d_resp_tag_q   <= d_resp_tag_d;
            d_resp_rdata_q <= d_resp_rdata_d;
            d_resp_err_q   <= d_resp_err_d;
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_size_o     = mem_size_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign fetch_ack_o    = fetch_ack_q;
    assign fetch_rdata_o  = fetch_rdata_q;
    assign fetch_err_o    = fetch_err_q;
    assign d_resp_valid_o = d_resp_valid_q;
    assign d_resp_tag_o   = d_resp_tag_q;
    assign d_resp_rdata_o = d_resp_rdata_q;
    assign d_resp_err_o   = d_resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requesters, a small memory responder and a
// response scoreboard that checks every fetch ack / load-store response in order.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 64, DW = 64, TW = 4, TO = 4;

    logic          clk_i = 1'b0, rst_ni = 1'b0;
    logic          flush_i, fetch_req_i, fetch_ack_o, fetch_err_o;
    logic [AW-1:0] fetch_addr_i, d_addr_i, mem_addr_o;
    logic [1:0]    fetch_size_i, d_size_i, mem_size_o;
    logic [DW-1:0] fetch_rdata_o, d_wdata_i, d_resp_rdata_o, mem_wdata_o, mem_rdata_i;
    logic          d_valid_i, d_ready_o, d_we_i, d_resp_valid_o, d_resp_err_o;
    logic [TW-1:0] d_tag_i, d_resp_tag_o;
    logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_size_i(fetch_size_i),
        .fetch_ack_o(fetch_ack_o), .fetch_rdata_o(fetch_rdata_o), .fetch_err_o(fetch_err_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_size_i(d_size_i), .d_wdata_i(d_wdata_i), .d_tag_i(d_tag_i),
        .d_resp_valid_o(d_resp_valid_o), .d_resp_tag_o(d_resp_tag_o),
        .d_resp_rdata_o(d_resp_rdata_o), .d_resp_err_o(d_resp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_size_o(mem_size_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected responses, in issue order.
    typedef struct {
        bit          is_d;
        logic [3:0]  tag;
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    int   n_resp = 0, resp_cyc = 0;

    task automatic push_exp(input bit is_d, input logic [3:0] tag, input logic [63:0] rdata,
                            input logic err);
        exp_t e;
        e.is_d = is_d; e.tag = tag; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i); #3;
            if (fetch_ack_o || d_resp_valid_o) begin
                resp_cyc = cyc;
                n_resp++;
                check("resp_exclusive", {63'd0, fetch_ack_o & d_resp_valid_o}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got fetch_ack=%0b d_resp_valid=%0b expected none",
                             fetch_ack_o, d_resp_valid_o);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", {63'd0, d_resp_valid_o}, {63'd0, e.is_d});
                    if (e.is_d) begin
                        check("d_resp_tag", d_resp_tag_o, e.tag);
                        check("d_resp_rdata", d_resp_rdata_o, e.rdata);
                        check("d_resp_err", d_resp_err_o, e.err);
                    end else begin
                        check("fetch_rdata", fetch_rdata_o, e.rdata);
                        check("fetch_err", fetch_err_o, e.err);
                    end
                end
            end
        end
    end

    // Memory responder: grant after gnt_lat waiting cycles, respond rsp_lat cycles after grant.
    int          gnt_lat = 0, rsp_lat = 1, late_at = 0, gnt_cyc = 0;
    bit          rsp_en = 1'b1;
    logic [63:0] rsp_data = 64'd0;
    logic        st_err = 1'b0, ld_err = 1'b0;
    logic [63:0] gnt_log[$];

    initial begin : mem_model
        int   ph, wcnt, rcnt;
        logic we_l;
        ph = 0; wcnt = 0; rcnt = 0; we_l = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
            if (!rst_ni) begin
                ph = 0; wcnt = 0;
            end else if (ph == 0) begin
                if (mem_req_o) begin
                    if (wcnt >= gnt_lat) begin
                        mem_gnt_i = 1'b1;
                        gnt_cyc = cyc;
                        gnt_log.push_back(mem_addr_o);
                        we_l = mem_we_o;
                        ph = 1; rcnt = 0; wcnt = 0;
                    end else wcnt++;
                end else wcnt = 0;
            end else begin
                rcnt++;
                if ((rsp_en && rcnt == rsp_lat) || (!rsp_en && rcnt == late_at)) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rsp_data;
                    mem_err_i    = we_l ? st_err : ld_err;
                    ph = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_resp(input int n0, input string name);
        int k = 0;
        while (n_resp == n0 && k < 30) begin
            @(posedge clk_i); #4;
            k++;
        end
        if (n_resp == n0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no response expected one within 30 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            step();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic fetch_wait(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (fetch_ack_o) begin
                got = 1'b1;
                fetch_req_i = 1'b0;
            end
        end
        check(name, {63'd0, got}, 64'd1);
    endtask

    task automatic d_hs(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (d_ready_o) got = 1'b1;
            step();
        end
        d_valid_i = 1'b0;
        check(name, {63'd0, got}, 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   dn, fn, c0, n0;
        bit   hs, stable_req, stable_pay, rdy_low;
        logic [63:0] exp_addr[6];
        flush_i = 0; fetch_req_i = 0; fetch_addr_i = '0; fetch_size_i = 2'd3;
        d_valid_i = 0; d_we_i = 0; d_addr_i = '0; d_size_i = 2'd3; d_wdata_i = '0; d_tag_i = '0;

        // Reset values
        repeat (3) step();
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_fetch_ack", fetch_ack_o, 0);
        check("rst_d_resp_valid", d_resp_valid_o, 0);
        check("rst_d_resp_tag", d_resp_tag_o, 0);
        check("rst_fetch_rdata", fetch_rdata_o, 0);
        #1 check("rst_d_ready", d_ready_o, 0);

        // Contention from reset: expect D,F,D,F,D,F
        gnt_lat = 0; rsp_lat = 1; rsp_en = 1; rsp_data = 64'h5555; ld_err = 0;
        fetch_req_i = 1; fetch_addr_i = 64'h1000;
        d_valid_i = 1; d_addr_i = 64'h2000; d_tag_i = 4'd0;
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b1, 4'(i), 64'h5555, 1'b0);
            push_exp(1'b0, 4'd0, 64'h5555, 1'b0);
        end
        gnt_log.delete();
        step();
        rst_ni = 1'b1;
        dn = 0; fn = 0;
        for (int i = 0; i < 60 && (dn < 3 || fn < 3); i++) begin
            #1 hs = d_valid_i && d_ready_o;
            step();
            if (hs) begin
                dn++;
                if (dn < 3) begin
                    d_tag_i = 4'(dn);
                    d_addr_i = 64'h2000 + 64'(8 * dn);
                end else d_valid_i = 1'b0;
            end
            if (fetch_ack_o) begin
                fn++;
                if (fn < 3) fetch_addr_i = 64'h1000 + 64'(8 * fn);
                else fetch_req_i = 1'b0;
            end
        end
        check("cont_d_count", dn, 3);
        check("cont_f_count", fn, 3);
        exp_addr = '{64'h2000, 64'h1000, 64'h2008, 64'h1008, 64'h2010, 64'h1010};
        check("cont_gnt_count", gnt_log.size(), 6);
        if (gnt_log.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("cont_gnt_addr%0d", i), gnt_log[i], exp_addr[i]);
        drain("cont_drain");

        // Single load: ready at cycle 0, req cycles 1-2, response at cycle 5
        step();
        gnt_lat = 1; rsp_lat = 2; rsp_data = 64'hDEAD;
        d_valid_i = 1; d_we_i = 0; d_addr_i = 64'h80; d_tag_i = 4'd5; d_size_i = 2'd3;
        push_exp(1'b1, 4'd5, 64'hDEAD, 1'b0);
        c0 = cyc; n0 = n_resp;
        #1 check("load_ready_c0", d_ready_o, 1);
        step();
        d_valid_i = 0;
        check("load_req_c1", mem_req_o, 1);
        check("load_addr_c1", mem_addr_o, 64'h80);
        check("load_we_c1", mem_we_o, 0);
        step();
        check("load_req_c2", mem_req_o, 1);
        step();
        check("load_req_c3", mem_req_o, 0);
        wait_resp(n0, "load_resp");
        check("load_resp_cycle", resp_cyc - c0, 5);
        drain("load_drain");

        // Grant stall with a store, followed by a queued load; store returns an error
        step();
        gnt_lat = 10; rsp_lat = 1; rsp_data = 64'hCAFE; st_err = 1; ld_err = 0;
        d_valid_i = 1; d_we_i = 1; d_addr_i = 64'h300; d_wdata_i = 64'h1234_5678;
        d_tag_i = 4'd7; d_size_i = 2'd2;
        push_exp(1'b1, 4'd7, 64'h0, 1'b1);
        push_exp(1'b1, 4'd9, 64'hCAFE, 1'b0);
        #1 check("stall_ready_c0", d_ready_o, 1);
        step();
        d_we_i = 0; d_addr_i = 64'h308; d_wdata_i = '0; d_tag_i = 4'd9; d_size_i = 2'd3;
        stable_req = 1; stable_pay = 1; rdy_low = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_req_o !== 1'b1) stable_req = 0;
            if (mem_addr_o !== 64'h300 || mem_wdata_o !== 64'h1234_5678 || mem_we_o !== 1'b1
                || mem_size_o !== 2'd2) stable_pay = 0;
            if (d_ready_o !== 1'b0) rdy_low = 0;
            step();
        end
        check("stall_req_held", {63'd0, stable_req}, 64'd1);
        check("stall_payload_held", {63'd0, stable_pay}, 64'd1);
        check("stall_ready_low", {63'd0, rdy_low}, 64'd1);
        gnt_lat = 0;
        d_hs("stall_second_hs");
        drain("stall_drain");
        st_err = 0;

        // Flush a fetch in RESP: no ack; next fetch acked normally
        step();
        gnt_lat = 0; rsp_lat = 3; rsp_data = 64'hBEEF;
        gnt_log.delete();
        fetch_req_i = 1; fetch_addr_i = 64'h400;
        step();
        step();
        flush_i = 1; fetch_req_i = 0;
        step();
        flush_i = 0;
        repeat (5) step();
        push_exp(1'b0, 4'd0, 64'hBEEF, 1'b0);
        fetch_req_i = 1; fetch_addr_i = 64'h440;
        fetch_wait("flush_next_ack");
        check("flush_gnt_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("flush_gnt_addr0", gnt_log[0], 64'h400);
            check("flush_gnt_addr1", gnt_log[1], 64'h440);
        end
        drain("flush_drain");

        // Timeout: no rvalid -> error 5 cycles after grant, late rvalid ignored
        step();
        gnt_lat = 0; rsp_en = 0; late_at = 7; rsp_data = 64'h7777;
        d_valid_i = 1; d_we_i = 0; d_addr_i = 64'h500; d_tag_i = 4'd3;
        push_exp(1'b1, 4'd3, 64'h0, 1'b1);
        n0 = n_resp;
        d_hs("to_hs");
        wait_resp(n0, "to_resp");
        check("to_resp_cycle", resp_cyc - gnt_cyc, 5);
        repeat (10) step();
        check("to_req_idle", mem_req_o, 0);
        drain("to_drain");
        rsp_en = 1;

        // Async reset during REQ abandons the transaction
        step();
        gnt_lat = 20;
        d_valid_i = 1; d_addr_i = 64'h600; d_tag_i = 4'd2;
        d_hs("arst_hs");
        check("arst_req_before", mem_req_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_req_cleared", mem_req_o, 0);
        check("arst_addr_cleared", mem_addr_o, 0);
        step();
        step();
        rst_ni = 1'b1;
        gnt_lat = 0; rsp_lat = 1; rsp_data = 64'h99;
        push_exp(1'b0, 4'd0, 64'h99, 1'b0);
        fetch_req_i = 1; fetch_addr_i = 64'h700;
        fetch_wait("arst_fetch_ack");
        drain("arst_drain");

        repeat (3) step();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
